cpu: RTL and testbench

- Minimal 16-bit multicycle accumulator-less CPU with internal word memory, 8-entry register file, program counter and a state-machine control matrix.
- Top-level block of the A09 processor. Only clock and reset are external; the program is preloaded into internal memory by the bench.
- Observability is through fixed hierarchical names.

---
 rtl/cpu.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_cpu.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// A09 multicycle CPU: control FSM on posedge, datapath on negedge, internal memory and register file.
// Optional macro CPU_TRACE_EN prints a decode/halt trace; logic is unchanged by it.
package cpu_pkg;
  typedef enum logic [2:0] {
    S_Idle, S_Reset, S_FetchPCtoMEM, S_FetchMEMtoIR, S_Decode, S_Execute, S_Halt
  } state_t;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_LDI = 4'd3;
  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_ST  = 4'd5;
  localparam logic [3:0] OP_STX = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8;
endpackage

module cpu_memory #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [AddrWidth-1:0] i_raddr_a,
  output logic [DataWidth-1:0] o_rdata_a,
  input  logic [AddrWidth-1:0] i_raddr_b,
  output logic [DataWidth-1:0] o_rdata_b
);
  logic [DataWidth-1:0] mem [0:2**AddrWidth-1];

  always_ff @(negedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = mem[i_raddr_a];
  assign o_rdata_b = mem[i_raddr_b];
endmodule

module cpu_regfile #(
  parameter int DataWidth = 16
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [2:0]           i_waddr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [2:0]           i_raddr_a,
  output logic [DataWidth-1:0] o_rdata_a,
  input  logic [2:0]           i_raddr_b,
  output logic [DataWidth-1:0] o_rdata_b,
  input  logic [2:0]           i_raddr_s,
  output logic [DataWidth-1:0] o_rdata_s
);
  logic [DataWidth-1:0] reg_file [0:7];

  always_ff @(negedge i_clk) begin
    if (i_we) reg_file[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = reg_file[i_raddr_a];
  assign o_rdata_b = reg_file[i_raddr_b];
  assign o_rdata_s = reg_file[i_raddr_s];
endmodule

module cpu_control
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_op,
  output state_t     o_state,
  output logic       o_mar_ld,
  output logic       o_ir_ld,
  output logic       o_exec,
  output logic       o_pc_inc_n,
  output logic       o_halt
);
  state_t state = S_Idle;
  state_t next_state;
  // High for exactly one cycle after power-up (S_Idle) and after entering S_Halt.
  logic   r_halt_first = 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_Reset;
      r_halt_first <= 1'b0;
    end else begin
      state        <= next_state;
      r_halt_first <= (next_state == S_Halt) && (state != S_Halt);
    end
  end

  always_comb begin
    next_state = state;
    o_mar_ld   = 1'b0;
    o_ir_ld    = 1'b0;
    o_exec     = 1'b0;
    o_pc_inc_n = 1'b1;
    case (state)
      S_Idle:         next_state = S_Idle;
      S_Reset:        next_state = S_FetchPCtoMEM;
      S_FetchPCtoMEM: begin
        o_mar_ld   = 1'b1;
        o_pc_inc_n = 1'b0;
        next_state = S_FetchMEMtoIR;
      end
      S_FetchMEMtoIR: begin
        o_ir_ld    = 1'b1;
        next_state = S_Decode;
      end
      S_Decode:       next_state = (i_op == OP_HLT) ? S_Halt : S_Execute;
      S_Execute: begin
        o_exec     = 1'b1;
        next_state = S_FetchPCtoMEM;
      end
      S_Halt:         next_state = S_Halt;
      default:        next_state = S_Reset;
    endcase
  end

  assign o_state = state;
  assign o_halt  = r_halt_first;
endmodule

module cpu
  import cpu_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8,
  parameter int WordSize  = 1
) (
  input logic Clk,
  input logic Reset
);
  logic                 halt;
  logic                 pc_inc;
  logic [DataWidth-1:0] pc_to_out;

  logic [DataWidth-1:0] r_pc;
  logic [DataWidth-1:0] r_ir;
  logic [AddrWidth-1:0] r_mar;
  logic                 r_z;

  state_t               w_state;
  logic                 w_mar_ld, w_ir_ld, w_exec;
  logic [3:0]           w_op;
  logic [DataWidth-1:0] w_ra_val, w_rb_val, w_rs_val, w_alu;
  logic [DataWidth-1:0] w_mem_a, w_mem_b;
  logic [AddrWidth-1:0] w_pc_next, w_imm_addr, w_stx_addr;
  logic                 w_rf_we, w_mem_we;
  logic [DataWidth-1:0] w_rf_wdata;
  logic [AddrWidth-1:0] w_mem_waddr;

  assign w_op       = r_ir[15:12];
  assign w_imm_addr = AddrWidth'(r_ir[7:0]);
  assign w_stx_addr = w_ra_val[AddrWidth-1:0] + AddrWidth'(r_ir[5:0]);
  assign w_pc_next  = r_pc[AddrWidth-1:0] + AddrWidth'(WordSize);
  assign w_alu      = (w_op == OP_SUB) ? (w_ra_val - w_rb_val) : (w_ra_val + w_rb_val);
  assign pc_to_out  = r_pc;

  cpu_control ControlMatrix (
    .i_clk      (Clk),
    .i_rst_n    (Reset),
    .i_op       (w_op),
    .o_state    (w_state),
    .o_mar_ld   (w_mar_ld),
    .o_ir_ld    (w_ir_ld),
    .o_exec     (w_exec),
    .o_pc_inc_n (pc_inc),
    .o_halt     (halt)
  );

  cpu_memory #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) memory (
    .i_clk     (Clk),
    .i_we      (w_mem_we),
    .i_waddr   (w_mem_waddr),
    .i_wdata   (w_rs_val),
    .i_raddr_a (r_mar),
    .o_rdata_a (w_mem_a),
    .i_raddr_b (w_imm_addr),
    .o_rdata_b (w_mem_b)
  );

  cpu_regfile #(.DataWidth(DataWidth)) RegFile (
    .i_clk     (Clk),
    .i_we      (w_rf_we),
    .i_waddr   (r_ir[11:9]),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (r_ir[8:6]),
    .o_rdata_a (w_ra_val),
    .i_raddr_b (r_ir[5:3]),
    .o_rdata_b (w_rb_val),
    .i_raddr_s (r_ir[11:9]),
    .o_rdata_s (w_rs_val)
  );

  always_comb begin
    w_rf_we     = 1'b0;
    w_rf_wdata  = '0;
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    if (w_exec) begin
      case (w_op)
        OP_ADD, OP_SUB: begin
          w_rf_we    = 1'b1;
          w_rf_wdata = w_alu;
        end
        OP_LDI: begin
          w_rf_we    = 1'b1;
          w_rf_wdata = DataWidth'(r_ir[7:0]);
        end
        OP_LD: begin
          w_rf_we    = 1'b1;
          w_rf_wdata = w_mem_b;
        end
        OP_ST: begin
          w_mem_we    = 1'b1;
          w_mem_waddr = w_imm_addr;
        end
        OP_STX: begin
          w_mem_we    = 1'b1;
          w_mem_waddr = w_stx_addr;
        end
        default: ;
      endcase
    end
  end

  // Datapath runs on the falling edge so it sees controls decoded from a settled state.
  always_ff @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_z   <= 1'b0;
    end else begin
      if (w_mar_ld) begin
        r_mar <= r_pc[AddrWidth-1:0];
        r_pc  <= DataWidth'(w_pc_next);
      end
      if (w_ir_ld) r_ir <= w_mem_a;
      if (w_exec) begin
        case (w_op)
          OP_ADD, OP_SUB: r_z <= (w_alu == '0);
          OP_JMP:         r_pc <= DataWidth'(w_imm_addr);
          OP_BEQ:         if (r_z) r_pc <= DataWidth'(w_imm_addr);
          default: ;
        endcase
      end
    end
  end

`ifdef CPU_TRACE_EN
  function automatic string mnemonic(input logic [3:0] op);
    case (op)
      OP_HLT:  return "HLT";
      OP_ADD:  return "ADD";
      OP_SUB:  return "SUB";
      OP_LDI:  return "LDI";
      OP_LD:   return "LD";
      OP_ST:   return "ST";
      OP_STX:  return "STX";
      OP_JMP:  return "JMP";
      OP_BEQ:  return "BEQ";
      default: return "NOP";
    endcase
  endfunction

  always @(posedge Clk) begin
    if (Reset && w_state == S_FetchMEMtoIR)
      $display("%0t PC=%h IR=%h %s", $time, r_mar, r_ir, mnemonic(r_ir[15:12]));
    if (Reset && w_state == S_Decode && w_op == OP_HLT)
      $display("HALT");
  end
`else
  // Trace output compiled out; datapath unaffected.
`endif
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: preloads programs into internal memory and checks state via hierarchy.
module tb_cpu;
  import cpu_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  cpu #(.DataWidth(16), .AddrWidth(8), .WordSize(1)) dut (
    .Clk   (Clk),
    .Reset (Reset)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int unsigned addr, input logic [15:0] w);
    dut.memory.mem[addr] = w;
  endtask

  task automatic wait_state(input state_t s, input string tag);
    int unsigned n = 0;
    while (dut.ControlMatrix.state !== s && n < 300) begin
      @(posedge Clk); #1; n++;
    end
    check(tag, 32'(dut.ControlMatrix.state), 32'(s));
  endtask

  task automatic wait_exec(input logic [15:0] ir, input string tag);
    int unsigned n = 0;
    while (!(dut.ControlMatrix.state === S_Execute && dut.r_ir === ir) && n < 300) begin
      @(posedge Clk); #1; n++;
    end
    check(tag, 32'(dut.ControlMatrix.state === S_Execute && dut.r_ir === ir), 32'd1);
  endtask

  task automatic enter_reset();
    Reset = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge Clk); #2;
    Reset = 1'b1;
  endtask

  initial begin
    // Power-up: idle with a one-cycle halt pulse.
    #1;
    check("idle_state_t0", 32'(dut.ControlMatrix.state), 32'(S_Idle));
    check("idle_halt_t0", 32'(dut.halt), 32'd1);
    @(posedge Clk); #2;
    check("idle_halt_fall", 32'(dut.halt), 32'd0);
    check("idle_state_hold", 32'(dut.ControlMatrix.state), 32'(S_Idle));

    // Program 1: LDI/LDI/STX/HLT
    @(negedge Clk); #2;
    enter_reset();
    check("rst_state", 32'(dut.ControlMatrix.state), 32'(S_Reset));
    check("rst_pc", 32'(dut.pc_to_out), 32'h0);
    check("rst_halt", 32'(dut.halt), 32'd0);
    load(0, 16'h3205);
    load(1, 16'h340A);
    load(2, 16'h6440);
    load(3, 16'h0000);
    release_reset();
    @(posedge Clk); #1;
    check("fetch_state", 32'(dut.ControlMatrix.state), 32'(S_FetchPCtoMEM));
    check("fetch_next", 32'(dut.ControlMatrix.next_state), 32'(S_FetchMEMtoIR));
    check("fetch_pcinc_low", 32'(dut.pc_inc), 32'd0);
    @(negedge Clk); #1;
    check("fetch_pc_inc", 32'(dut.pc_to_out), 32'h0001);
    wait_state(S_Halt, "p1_halt_reached");
    check("p1_halt_pulse", 32'(dut.halt), 32'd1);
    check("p1_pcinc_high", 32'(dut.pc_inc), 32'd1);
    @(posedge Clk); #1;
    check("p1_halt_fall", 32'(dut.halt), 32'd0);
    check("p1_halt_stay", 32'(dut.ControlMatrix.state), 32'(S_Halt));
    check("p1_mem5", 32'(dut.memory.mem[5]), 32'h000A);
    check("p1_r1", 32'(dut.RegFile.reg_file[1]), 32'h0005);
    check("p1_r2", 32'(dut.RegFile.reg_file[2]), 32'h000A);

    // Program 2: SUB sets Z, BEQ taken to 0x10, ADD clears Z
    enter_reset();
    load(0, 16'h3203);
    load(1, 16'h3403);
    load(2, 16'h2650);
    load(3, 16'h8010);
    load(4, 16'h0000);
    load(16, 16'h1850);
    load(17, 16'h0000);
    release_reset();
    wait_exec(16'h8010, "p2_beq_exec");
    check("p2_z_after_sub", 32'(dut.r_z), 32'd1);
    check("p2_r3_zero", 32'(dut.RegFile.reg_file[3]), 32'h0000);
    wait_state(S_Halt, "p2_halt_reached");
    check("p2_r4", 32'(dut.RegFile.reg_file[4]), 32'h0006);
    check("p2_z_after_add", 32'(dut.r_z), 32'd0);
    check("p2_pc_taken", 32'(dut.pc_to_out), 32'h0012);

    // Program 3: ADD wrap, STX address wrap, PC wrap at 0xFF
    enter_reset();
    load(0, 16'h32FF);
    load(1, 16'h4A80);
    load(2, 16'h3C01);
    load(3, 16'h1F70);
    load(4, 16'h6A42);
    load(5, 16'h70FF);
    load(128, 16'hFFFF);
    load(255, 16'h70FF);
    release_reset();
    begin
      int unsigned n = 0;
      while (!(dut.ControlMatrix.state === S_FetchMEMtoIR && dut.r_mar === 8'hFF) && n < 300) begin
        @(posedge Clk); #1; n++;
      end
      check("p3_reach_ff", 32'(dut.r_mar), 32'hFF);
    end
    check("p3_pc_wrap", 32'(dut.pc_to_out), 32'h0000);
    check("p3_r1", 32'(dut.RegFile.reg_file[1]), 32'h00FF);
    check("p3_add_wrap", 32'(dut.RegFile.reg_file[7]), 32'h0000);
    check("p3_z_wrap", 32'(dut.r_z), 32'd1);
    check("p3_stx_wrap", 32'(dut.memory.mem[1]), 32'hFFFF);

    // Program 4: reset during ST execute suppresses the store
    enter_reset();
    load(0, 16'h3255);
    load(1, 16'h5240);
    load(2, 16'h0000);
    load(64, 16'h1234);
    release_reset();
    wait_exec(16'h5240, "p4_st_exec");
    enter_reset();
    check("p4_rst_state", 32'(dut.ControlMatrix.state), 32'(S_Reset));
    check("p4_rst_pc", 32'(dut.pc_to_out), 32'h0);
    @(negedge Clk); #1;
    check("p4_store_blocked", 32'(dut.memory.mem[64]), 32'h1234);
    check("p4_rst_hold", 32'(dut.ControlMatrix.state), 32'(S_Reset));
    release_reset();
    wait_state(S_Halt, "p4_halt_reached");
    check("p4_store_done", 32'(dut.memory.mem[64]), 32'h0055);
    check("p4_pc_end", 32'(dut.pc_to_out), 32'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
